// File: rtl/if_fetch_unit_pkg.sv
// Shared widths, stall encodings and hold-buffer state encoding for the IF stage.
package if_fetch_unit_pkg;

  localparam int unsigned IfToIdWd   = 33;
  localparam int unsigned BrWd       = 33;
  localparam int unsigned StallBusWd = 6;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [31:0] ResetPcVal = 32'hBFBF_FFFC;

  typedef enum logic {
    HstatePass = 1'b0,
    HstateHold = 1'b1
  } hstate_e;

endpackage

// File: rtl/if_fetch_unit_inst_hold_buf.sv
// Captures the SRAM read data when ID stalls so ID keeps seeing the word that
// matches its latched PC.
module if_fetch_unit_inst_hold_buf
  import if_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_id_i,
  input  logic [31:0] inst_sram_rdata_i,
  output logic [31:0] id_inst_o
);

  hstate_e     hstate_q;
  logic [31:0] hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hstate_q <= HstatePass;
      hold_q   <= '0;
    end else begin
      unique case (hstate_q)
        HstatePass: begin
          if (stall_id_i == Stop) begin
            hstate_q <= HstateHold;
            hold_q   <= inst_sram_rdata_i;
          end
        end
        HstateHold: begin
          if (stall_id_i == NoStop) begin
            hstate_q <= HstatePass;
          end
        end
        default: hstate_q <= HstatePass;
      endcase
    end
  end

  assign id_inst_o = (hstate_q == HstateHold) ? hold_q : inst_sram_rdata_i;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues SRAM reads, and remembers a branch
// resolved by ID while IF is stalled.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ResetPcVal
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [StallBusWd-1:0] stall,
  input  logic [BrWd-1:0]       br_bus,
  output logic [IfToIdWd-1:0]   if_to_id_bus,
  output logic                  inst_sram_en,
  output logic [3:0]            inst_sram_wen,
  output logic [31:0]           inst_sram_addr,
  output logic [31:0]           inst_sram_wdata,
  input  logic [31:0]           inst_sram_rdata,
  output logic [31:0]           id_inst
);

  logic        br_e;
  logic [31:0] br_addr;
  logic [31:0] pc_q, pc_d;
  logic        ce_q;
  logic        br_pend_q;
  logic [31:0] br_pend_addr_q;
  logic        unused_stall;

  assign {br_e, br_addr} = br_bus;
  assign unused_stall    = ^stall[StallBusWd-1:2];

  always_comb begin
    pc_d = pc_q + 32'd4;
    if (br_e) begin
      pc_d = br_addr;
    end else if (br_pend_q) begin
      pc_d = br_pend_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      ce_q           <= 1'b0;
      br_pend_q      <= 1'b0;
      br_pend_addr_q <= '0;
    end else if (stall[0] == NoStop) begin
      pc_q      <= pc_d;
      ce_q      <= 1'b1;
      br_pend_q <= 1'b0;
    end else if (br_e) begin
      // Latest branch wins if ID resolves more than one while IF is frozen.
      br_pend_q      <= 1'b1;
      br_pend_addr_q <= br_addr;
    end
  end

  assign inst_sram_en    = ce_q;
  assign inst_sram_addr  = pc_q;
  assign inst_sram_wen   = 4'b0;
  assign inst_sram_wdata = 32'b0;
  assign if_to_id_bus    = {ce_q, pc_q};

  if_fetch_unit_inst_hold_buf u_inst_hold_buf (
    .clk               (clk),
    .rst               (rst),
    .stall_id_i        (stall[1]),
    .inst_sram_rdata_i (inst_sram_rdata),
    .id_inst_o         (id_inst)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit using a queue of expected results.
module tb_if_fetch_unit;

  localparam logic [31:0] ResetPc = 32'hBFBF_FFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic [31:0] id_inst;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];
  logic [32:0] exp_v;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .RESET_PC (ResetPc)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_bus          (br_bus),
    .if_to_id_bus    (if_to_id_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .id_inst         (id_inst)
  );

  always @(posedge clk) begin
    if (!rst && stall[0] == 1'b0 && stall[1] == 1'b1) begin
      errors++;
      $display("FAIL illegal_stall: stall=%b (ID stalled while IF runs)", stall);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pops the next expected {en, addr} and compares against the fetch bus.
  task automatic test_fetch_pop(input string name);
    exp_v = exp_q.pop_front();
    checks++;
    if (if_to_id_bus !== exp_v || inst_sram_addr !== exp_v[31:0]
        || inst_sram_en !== exp_v[32]) begin
      errors++;
      $display("FAIL %s: bus=%h addr=%h en=%b expected bus=%h", name, if_to_id_bus,
               inst_sram_addr, inst_sram_en, exp_v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stall = 6'b0;
    br_bus = '0;
    inst_sram_rdata = 32'h1234_5678;
    step();
    step();
    step();
    exp_q.push_back({1'b0, ResetPc});
    test_fetch_pop("reset_bus");
    checks++;
    if (inst_sram_wen !== 4'b0 || inst_sram_wdata !== 32'b0) begin
      errors++;
      $display("FAIL reset_write: wen=%h wdata=%h expected 0/0", inst_sram_wen, inst_sram_wdata);
    end
    checks++;
    if (id_inst !== 32'h1234_5678) begin
      errors++;
      $display("FAIL reset_id_inst: got %h expected %h", id_inst, 32'h1234_5678);
    end
    rst = 1'b0;
    exp_q.push_back({1'b1, 32'hBFC0_0000});
    exp_q.push_back({1'b1, 32'hBFC0_0004});
    exp_q.push_back({1'b1, 32'hBFC0_0008});
    for (int i = 0; i < 3; i++) begin
      step();
      test_fetch_pop("release_seq");
    end
  endtask

  task automatic test_branch();
    br_bus = {1'b1, 32'hBFC0_0100};
    exp_q.push_back({1'b1, 32'hBFC0_0100});
    exp_q.push_back({1'b1, 32'hBFC0_0104});
    step();
    br_bus = '0;
    test_fetch_pop("branch_target");
    step();
    test_fetch_pop("branch_seq");
  endtask

  task automatic test_id_stall_hold();
    inst_sram_rdata = 32'h3C01_1234;
    stall = 6'b000011;
    step();
    inst_sram_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b0, 32'h3C01_1234});
      exp_q.push_back({1'b1, 32'hBFC0_0104});
      if (i > 0) step();
      exp_v = exp_q.pop_front();
      checks++;
      if (id_inst !== exp_v[31:0]) begin
        errors++;
        $display("FAIL hold_id_inst: got %h expected %h", id_inst, exp_v[31:0]);
      end
      test_fetch_pop("hold_pc_frozen");
    end
    stall = 6'b0;
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    exp_q.push_back({1'b1, 32'hBFC0_0108});
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (id_inst !== exp_v[31:0]) begin
      errors++;
      $display("FAIL hold_release: got %h expected %h", id_inst, exp_v[31:0]);
    end
    test_fetch_pop("hold_release_pc");
  endtask

  task automatic test_branch_during_stall();
    stall = 6'b000001;
    exp_q.push_back({1'b1, 32'hBFC0_0108});
    step();
    test_fetch_pop("ifstall_frozen");
    br_bus = {1'b1, 32'hBFC0_0200};
    exp_q.push_back({1'b1, 32'hBFC0_0108});
    step();
    br_bus = '0;
    test_fetch_pop("ifstall_br_frozen");
    step();
    stall = 6'b0;
    exp_q.push_back({1'b1, 32'hBFC0_0200});
    exp_q.push_back({1'b1, 32'hBFC0_0204});
    exp_q.push_back({1'b1, 32'hBFC0_0208});
    step();
    test_fetch_pop("pend_target");
    step();
    test_fetch_pop("pend_cleared");
    step();
    test_fetch_pop("pend_cleared2");
  endtask

  task automatic test_branch_overwrite();
    stall = 6'b000011;
    br_bus = {1'b1, 32'hBFC0_0300};
    step();
    br_bus = {1'b1, 32'hBFC0_0340};
    step();
    br_bus = '0;
    step();
    stall = 6'b0;
    exp_q.push_back({1'b1, 32'hBFC0_0340});
    step();
    test_fetch_pop("pend_overwrite");
  endtask

  task automatic test_reset_mid();
    inst_sram_rdata = 32'hAAAA_5555;
    stall = 6'b000011;
    step();
    br_bus = {1'b1, 32'hBFC0_0400};
    step();
    br_bus = '0;
    rst = 1'b1;
    step();
    stall = 6'b0;
    inst_sram_rdata = 32'h0BAD_F00D;
    #1;
    exp_q.push_back({1'b0, ResetPc});
    test_fetch_pop("midrst_bus");
    checks++;
    if (id_inst !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL midrst_id_inst: got %h expected %h", id_inst, 32'h0BAD_F00D);
    end
    rst = 1'b0;
    exp_q.push_back({1'b1, 32'hBFC0_0000});
    step();
    test_fetch_pop("midrst_pend_dropped");
  endtask

  task automatic test_pc_wrap();
    br_bus = {1'b1, 32'hFFFF_FFFC};
    exp_q.push_back({1'b1, 32'hFFFF_FFFC});
    exp_q.push_back({1'b1, 32'h0000_0000});
    exp_q.push_back({1'b1, 32'h0000_0004});
    step();
    br_bus = '0;
    test_fetch_pop("wrap_target");
    step();
    test_fetch_pop("wrap_zero");
    step();
    test_fetch_pop("wrap_four");
  endtask

  initial begin
    test_reset();
    test_branch();
    test_id_stall_hold();
    test_branch_during_stall();
    test_branch_overwrite();
    test_reset_mid();
    test_pc_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
